// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the sequential MAC controller.
//   ACCW     - accumulator / adder width (always 32)
//   OPW_DEF  - default operand width
//   state_e  - controller state encoding
package mac_pkg;

    localparam int ACCW    = 32;
    localparam int OPW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        FIX,
        ACC,
        DONE
    } state_e;

endpackage

// File: rtl/mac_add32.sv
// mac_add32: the single 32-bit adder shared by every arithmetic step of the
// MAC controller.
//   x, y  in  32  addends
//   cin   in  1   carry-in
//   sum   out 32  x + y + cin (mod 2^32)
//   cout  out 1   carry-out of bit 31
module mac_add32
    import mac_pkg::*;
(
    input  logic [ACCW-1:0] x,
    input  logic [ACCW-1:0] y,
    input  logic            cin,
    output logic [ACCW-1:0] sum,
    output logic            cout
);

    assign {cout, sum} = {1'b0, x} + {1'b0, y} + {{ACCW{1'b0}}, cin};

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: sequential multiply-accumulate controller. Takes one operand
// pair per handshake, forms the product with a radix-2 shift-add loop, adds it
// to the 32-bit accumulator and presents the result on a valid/ready port.
// All additions go through one shared mac_add32 instance.
//
// Build option: MAC_SEQ_SIGNED_EN - two's-complement operands, a FIX state
// that negates the product, and signed-overflow detection.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  operand handshake (ready only in IDLE)
//   a, b               multiplicand, multiplier (OPW bits)
//   acc_clr            accumulate onto 0 instead of the current accumulator
//   out_valid/out_ready result handshake
//   acc_out            accumulator after the latest accumulate
//   ovf                sticky overflow, cleared by an accepted acc_clr pair
//   busy               high in every state except IDLE
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int OPW = OPW_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OPW-1:0]  a,
    input  logic [OPW-1:0]  b,
    input  logic            acc_clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] acc_out,
    output logic            ovf,
    output logic            busy
);

    localparam int CW = $clog2(OPW + 1);

    state_e          state_q, state_d;
    logic [ACCW-1:0] p_q, p_d;
    logic [ACCW-1:0] m_q, m_d;
    logic [OPW-1:0]  q_q, q_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic            clr_q, clr_d;
`ifdef MAC_SEQ_SIGNED_EN
    logic            sign_q, sign_d;
`endif

    logic [ACCW-1:0] add_x, add_y, add_sum;
    logic            add_cin, add_cout, add_ovf;
    logic [OPW-1:0]  a_mag, b_mag;

    mac_add32 u_add (
        .x    (add_x),
        .y    (add_y),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

`ifdef MAC_SEQ_SIGNED_EN
    // The adder is idle in IDLE, so it forms both magnitudes at once: the
    // conditionally inverted a and b sit in separate OPW-bit fields and each
    // field gets +1 when its operand is negative. A negative operand has
    // ~x <= 2^(OPW-1)-1, so the low field never carries into the high one.
    assign a_mag   = add_sum[OPW-1:0];
    assign b_mag   = add_sum[2*OPW-1:OPW];
    assign add_ovf = (add_x[ACCW-1] == add_y[ACCW-1]) &&
                     (add_sum[ACCW-1] != add_x[ACCW-1]);
`else
    assign a_mag   = a;
    assign b_mag   = b;
    assign add_ovf = add_cout;
`endif

    // Ready is forced low while reset is asserted, not just after it.
    assign in_ready  = rst_n && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        clr_d   = clr_q;
`ifdef MAC_SEQ_SIGNED_EN
        sign_d  = sign_q;
`endif
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;

        case (state_q)
            IDLE: begin
`ifdef MAC_SEQ_SIGNED_EN
                add_x = ACCW'({(b[OPW-1] ? ~b : b), (a[OPW-1] ? ~a : a)});
                add_y = ACCW'({b[OPW-1], {(OPW-1){1'b0}}, a[OPW-1]});
`endif
                if (in_valid) begin
                    p_d     = '0;
                    m_d     = ACCW'(a_mag);
                    q_d     = b_mag;
                    cnt_d   = '0;
                    clr_d   = acc_clr;
`ifdef MAC_SEQ_SIGNED_EN
                    sign_d  = a[OPW-1] ^ b[OPW-1];
`endif
                    state_d = MUL;
                end
            end
            MUL: begin
                add_x = p_q;
                add_y = q_q[0] ? m_q : '0;
                p_d   = add_sum;
                m_d   = m_q << 1;
                q_d   = q_q >> 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(OPW - 1)) begin
`ifdef MAC_SEQ_SIGNED_EN
                    state_d = FIX;
`else
                    state_d = ACC;
`endif
                end
            end
`ifdef MAC_SEQ_SIGNED_EN
            FIX: begin
                add_x   = ~p_q;
                add_cin = 1'b1;
                if (sign_q) p_d = add_sum;
                state_d = ACC;
            end
`endif
            ACC: begin
                add_x   = clr_q ? '0 : acc_q;
                add_y   = p_q;
                acc_d   = add_sum;
                ovf_d   = (clr_q ? 1'b0 : ovf_q) | add_ovf;
                state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            clr_q   <= 1'b0;
`ifdef MAC_SEQ_SIGNED_EN
            sign_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            clr_q   <= clr_d;
`ifdef MAC_SEQ_SIGNED_EN
            sign_q  <= sign_d;
`endif
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb_mac_seq_ctrl: directed-vector bench for mac_seq_ctrl. The driver pushes
// the hand-computed result of every accepted pair into a queue; a monitor pops
// and compares whenever the DUT presents a result. Follows MAC_SEQ_SIGNED_EN.
module tb_mac_seq_ctrl;

    localparam int OPW = 16;
`ifdef MAC_SEQ_SIGNED_EN
    localparam int LAT = OPW + 2;
`else
    localparam int LAT = OPW + 1;
`endif

    typedef struct {
        logic [31:0] acc;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [OPW-1:0]  a, b;
    logic            acc_clr;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     acc_out;
    logic            ovf;
    logic            busy;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    bit   seen   = 1'b0;

    mac_seq_ctrl #(.OPW(OPW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired (t=%0t)", name, $time);
    endtask

    // Offer one pair; push the expected result once it is accepted.
    task automatic send(input logic [OPW-1:0] ta, input logic [OPW-1:0] tb,
                        input logic tclr, input bit push,
                        input logic [31:0] eacc, input logic eovf);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            return;
        end
        a = ta; b = tb; acc_clr = tclr; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) exp_q.push_back('{acc: eacc, ovf: eovf, cyc: cyc});
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain_timeout");
    endtask

    // Monitor: compares every cycle a result is presented, which also covers
    // output stability while out_ready is held low.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                fail_now("unexpected_out_valid");
            end else begin
                if (!seen) begin
                    chk("latency", 32'(cyc - exp_q[0].cyc), 32'(LAT));
                    seen = 1'b1;
                end
                chk("acc_out", acc_out, exp_q[0].acc);
                chk("ovf", {31'b0, ovf}, {31'b0, exp_q[0].ovf});
                chk("in_ready_in_done", {31'b0, in_ready}, 32'd0);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; acc_clr = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_acc_out", acc_out, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1 chk("idle_in_ready", {31'b0, in_ready}, 32'd1);

`ifdef MAC_SEQ_SIGNED_EN
        send(16'hFFFD, 16'd5, 1'b1, 1'b1, 32'hFFFF_FFF1, 1'b0);   // -3 * 5
        send(16'h8000, 16'h8000, 1'b0, 1'b1, 32'h3FFF_FFF1, 1'b0); // 2^30 added
        drain();
`else
        send(16'd3, 16'd5, 1'b1, 1'b1, 32'd15, 1'b0);
        drain();
        send(16'd7, 16'd9, 1'b1, 1'b1, 32'd63, 1'b0);
        send(16'd10, 16'd10, 1'b0, 1'b1, 32'd163, 1'b0);
        // Preload 0xFFFF_0000, then walk up to the wrap.
        send(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 32'hFFFE_0001, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        send(16'd1, 16'd1, 1'b0, 1'b1, 32'd0, 1'b1);
        send(16'd2, 16'd3, 1'b0, 1'b1, 32'd6, 1'b1);   // ovf sticky
        send(16'd0, 16'd0, 1'b0, 1'b1, 32'd6, 1'b1);   // zero operands
        send(16'd1, 16'd1, 1'b1, 1'b1, 32'd1, 1'b0);   // clr drops ovf
        drain();
`endif

        // Stalled consumer; offered pairs must be ignored meanwhile.
        out_ready = 1'b0;
        send(16'd4, 16'd4, 1'b1, 1'b1, 32'd16, 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            if (!out_valid) fail_now("stall_wait");
        end
        a = 16'd9; b = 16'd9; acc_clr = 1'b1; in_valid = 1'b1;
        repeat (10) @(posedge clk);
        #1 in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        @(posedge clk); #1;
        chk("no_extra_accept_busy", {31'b0, busy}, 32'd0);
        chk("post_stall_acc", acc_out, 32'd16);

        // Reset during MUL step 5 aborts and clears the accumulator.
        send(16'd9, 16'd9, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_acc_out", acc_out, 32'd0);
        chk("midrst_ovf", {31'b0, ovf}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'd2, 16'd2, 1'b0, 1'b1, 32'd4, 1'b0);
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
